// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix-keypad scanner: matrix geometry,
// the per-sweep result encoding, the debounce FSM state encoding and a
// helper that classifies one sweep's key map.
// No ports (package).

package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Classification of one full four-column sweep.
    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } result_e;

    // Debounce FSM states.
    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_e;

    // Sweep result: kind plus key code. The code is forced to zero unless
    // the kind is RES_KEY, so two results compare equal exactly when they
    // describe the same keypad condition.
    typedef struct packed {
        result_e    kind;
        logic [3:0] code;
    } sweep_t;

    // Turns a key map (bit index row*NUM_COLS + col) into a sweep result.
    function automatic sweep_t classifySweep(input logic [NUM_KEYS-1:0] keys);
        sweep_t res;
        int     hits;
        hits     = 0;
        res.kind = RES_NONE;
        res.code = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                hits++;
                res.code = 4'(i);
            end
        end
        if (hits == 1) begin
            res.kind = RES_KEY;
        end else if (hits > 1) begin
            res.kind = RES_MULTI;
            res.code = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Resets to all-ones, i.e. "no row pulled low".
// Ports:
//   clock  - block clock
//   reset  - synchronous, active-high
//   rows_i - raw row lines from the keypad pins
//   rows_o - row lines synchronized to clock (2-cycle latency)

module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows_i,
    output logic [NUM_ROWS-1:0] rows_o
);

    logic [NUM_ROWS-1:0] stage1_q;
    logic [NUM_ROWS-1:0] stage2_q;

    // Two back-to-back flops give a metastable first stage a full cycle to
    // resolve before anything downstream looks at the rows.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage1_q <= '1;
            stage2_q <= '1;
        end else begin
            stage1_q <= rows_i;
            stage2_q <= stage1_q;
        end
    end

    assign rows_o = stage2_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// Multiplexed 4x4 matrix-keypad scanner. Drives one column low at a time,
// samples the synchronized rows at the end of each column dwell, classifies
// every full sweep, debounces the sweep results and reports committed keys.
// Ports:
//   clock     - single clock for the whole block
//   reset     - synchronous, active-high
//   row_in    - keypad rows, active-low, asynchronous to clock
//   col_out   - column drive, active-low, exactly one bit low
//   key_code  - last committed key, row*4 + col
//   key_valid - one-cycle strobe when a new key is committed
//   key_held  - high while a committed key is pressed

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE + 1);

    logic [NUM_ROWS-1:0] rowSync;
    logic [DW-1:0]       dwell_q;
    logic [1:0]          col_q;
    logic [NUM_COLS-1:0] colSel;
    logic                samplePoint;
    logic                sweepEnd;
    logic [NUM_KEYS-1:0] sampleKeys;
    logic [NUM_KEYS-1:0] sweepKeys;
    logic [NUM_KEYS-1:0] sweepAcc_q;
    sweep_t              sweepClass;
    sweep_t              sweepEff;
    sweep_t              result_q;
    logic                resultValid_q;
    sweep_t              prevResult_q;
    logic [SW-1:0]       stableCnt_q;
    logic [SW-1:0]       stableNext;
    logic                debounced;
    state_e              state_q, state_d;
    logic [3:0]          keyCode_q, keyCode_d;
    logic                keyValid_q, keyValid_d;

    keypad_row_sync u_row_sync (
        .clock  (clock),
        .reset  (reset),
        .rows_i (row_in),
        .rows_o (rowSync)
    );

    assign colSel      = NUM_COLS'(1) << col_q;
    assign col_out     = ~colSel;
    assign samplePoint = (dwell_q == DW'(SCAN_DIV - 1));
    assign sweepEnd    = samplePoint && (col_q == 2'd3);

    // Column sequencer: dwell on each column for SCAN_DIV cycles, then step
    // to the next column; the 2-bit index wraps 3 -> 0 on its own.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell_q <= '0;
            col_q   <= 2'd0;
        end else if (samplePoint) begin
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;
        end else begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    // Keys seen on the current column, placed at bit row*NUM_COLS + col.
    // Column 0 starts a fresh sweep, so the old accumulator is dropped there.
    always_comb begin
        sampleKeys = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                sampleKeys[r*NUM_COLS + c] = ~rowSync[r] & colSel[c];
            end
        end
        sweepKeys = ((col_q == 2'd0) ? '0 : sweepAcc_q) | sampleKeys;
    end

    // Ghosted multi-key sweeps are folded into NONE here, so they also count
    // as "no key" for stability tracking and release.
    always_comb begin
        sweepClass = classifySweep(sweepKeys);
        sweepEff   = sweepClass;
        if (sweepClass.kind == RES_MULTI) begin
            sweepEff.kind = RES_NONE;
            sweepEff.code = 4'd0;
        end
    end

    // Accumulate the sweep and register its classification on the cycle
    // after the column-3 sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            sweepAcc_q    <= '0;
            result_q      <= '{kind: RES_NONE, code: 4'd0};
            resultValid_q <= 1'b0;
        end else begin
            resultValid_q <= sweepEnd;
            if (samplePoint) begin
                sweepAcc_q <= sweepKeys;
            end
            if (sweepEnd) begin
                result_q <= sweepEff;
            end
        end
    end

    // Run length of identical sweep results, saturating at DEBOUNCE. The FSM
    // looks at the updated count in the same cycle it is stored.
    always_comb begin
        if (result_q != prevResult_q) begin
            stableNext = SW'(1);
        end else if (stableCnt_q == SW'(DEBOUNCE)) begin
            stableNext = stableCnt_q;
        end else begin
            stableNext = stableCnt_q + SW'(1);
        end
        debounced = resultValid_q && (stableNext == SW'(DEBOUNCE));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stableCnt_q  <= '0;
            prevResult_q <= '{kind: RES_NONE, code: 4'd0};
        end else if (resultValid_q) begin
            stableCnt_q  <= stableNext;
            prevResult_q <= result_q;
        end
    end

    // Debounce FSM next-state logic. A strobe fires on a fresh press and on
    // a roll-over to a different key; release is silent and keeps the code.
    always_comb begin
        state_d    = state_q;
        keyCode_d  = keyCode_q;
        keyValid_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (debounced && result_q.kind == RES_KEY) begin
                    state_d    = PRESSED;
                    keyCode_d  = result_q.code;
                    keyValid_d = 1'b1;
                end
            end
            PRESSED: begin
                if (debounced) begin
                    if (result_q.kind == RES_NONE) begin
                        state_d = RELEASED;
                    end else if (result_q.kind == RES_KEY && result_q.code != keyCode_q) begin
                        keyCode_d  = result_q.code;
                        keyValid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // FSM and output registers; code, strobe and held all change together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RELEASED;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
        end
    end

    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign key_held  = (state_q == PRESSED);

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (16-cycle
// sweep). A row model pulls row r low whenever a pressed key (r,c) has its
// column c driven low. Cycle indices inside each test count edges from a
// sweep boundary (column 0, dwell 0); with a key held from that boundary,
// the third sweep's column-3 sample falls in cycle 47 and the strobe is
// visible in cycle 49.

module tb_keypad_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressedMask = 16'h0000;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    // Row model: bit row*4+col of pressedMask means key (row,col) is down.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressedMask[r*4 + c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    keypad_scan #(
        .SCAN_DIV (4),
        .DEBOUNCE (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advances until the cycle in which column 0 is first driven again.
    task automatic waitSweepStart();
        logic [3:0] prevCol;
        bit         found;
        prevCol = col_out;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prevCol == 4'b0111 && col_out == 4'b1110) found = 1'b1;
            prevCol = col_out;
        end
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL sweep_start: got col_out %b, required a 0111->1110 step within 40 cycles", col_out);
        end
    endtask

    task automatic test_reset();
        logic [3:0] expCol;
        reset = 1'b1;
        repeat (3) tick();
        testsRun++;
        if (col_out !== 4'b1110) begin testsFailed++; $display("[TB] FAIL reset_col: got %b expected 1110", col_out); end
        testsRun++;
        if (key_code !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
        testsRun++;
        if (key_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
        testsRun++;
        if (key_held !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_held: got %b expected 0", key_held); end
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) tick();
            expCol = ~(4'b0001 << ((k / 4) % 4));
            testsRun++;
            if (col_out !== expCol) begin testsFailed++; $display("[TB] FAIL idle_col cycle %0d: got %b expected %b", k, col_out, expCol); end
            testsRun++;
            if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
                testsFailed++;
                $display("[TB] FAIL idle_outputs cycle %0d: got valid=%b held=%b code=%0d expected 0/0/0", k, key_valid, key_held, key_code);
            end
        end
    endtask

    task automatic test_single_press();
        waitSweepStart();
        pressedMask = 16'h0200;
        for (int k = 1; k <= 60; k++) begin
            tick();
            testsRun++;
            if (key_valid !== (k == 49)) begin testsFailed++; $display("[TB] FAIL press_valid cycle %0d: got %b expected %b", k, key_valid, (k == 49)); end
            testsRun++;
            if (key_held !== (k >= 49)) begin testsFailed++; $display("[TB] FAIL press_held cycle %0d: got %b expected %b", k, key_held, (k >= 49)); end
            if (k == 49) begin
                testsRun++;
                if (key_code !== 4'd9) begin testsFailed++; $display("[TB] FAIL press_code: got %0d expected 9", key_code); end
            end
        end
        for (int k = 0; k < 160; k++) begin
            tick();
            testsRun++;
            if (key_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL press_repeat cycle %0d: got valid %b expected 0", k, key_valid); end
        end
        testsRun++;
        if (key_held !== 1'b1 || key_code !== 4'd9) begin
            testsFailed++;
            $display("[TB] FAIL press_hold_end: got held=%b code=%0d expected 1/9", key_held, key_code);
        end
    endtask

    task automatic test_rollover();
        logic [3:0] expCode;
        waitSweepStart();
        pressedMask = 16'h8000;
        for (int k = 1; k <= 60; k++) begin
            tick();
            expCode = (k >= 49) ? 4'd15 : 4'd9;
            testsRun++;
            if (key_valid !== (k == 49)) begin testsFailed++; $display("[TB] FAIL roll_valid cycle %0d: got %b expected %b", k, key_valid, (k == 49)); end
            testsRun++;
            if (key_held !== 1'b1) begin testsFailed++; $display("[TB] FAIL roll_held cycle %0d: got %b expected 1", k, key_held); end
            testsRun++;
            if (key_code !== expCode) begin testsFailed++; $display("[TB] FAIL roll_code cycle %0d: got %0d expected %0d", k, key_code, expCode); end
        end
    endtask

    task automatic test_release();
        waitSweepStart();
        pressedMask = 16'h0000;
        for (int k = 1; k <= 60; k++) begin
            tick();
            testsRun++;
            if (key_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL release_valid cycle %0d: got %b expected 0", k, key_valid); end
            testsRun++;
            if (key_held !== (k < 49)) begin testsFailed++; $display("[TB] FAIL release_held cycle %0d: got %b expected %b", k, key_held, (k < 49)); end
            testsRun++;
            if (key_code !== 4'd15) begin testsFailed++; $display("[TB] FAIL release_code cycle %0d: got %0d expected 15", k, key_code); end
        end
    endtask

    // Key (0,3) toggles every 7 cycles until cycle 64, then stays down.
    // Column-3 samples see cycles 13,29,45,61,77,93,109: KEY,NONE,NONE,NONE,
    // then KEY for three sweeps, so the only strobe lands in cycle 113.
    task automatic test_bounce();
        waitSweepStart();
        pressedMask = 16'h0000;
        for (int k = 1; k <= 130; k++) begin
            tick();
            pressedMask = (k < 64 && ((k / 7) % 2 == 0)) ? 16'h0000 : 16'h0008;
            testsRun++;
            if (key_valid !== (k == 113)) begin testsFailed++; $display("[TB] FAIL bounce_valid cycle %0d: got %b expected %b", k, key_valid, (k == 113)); end
            if (k == 113) begin
                testsRun++;
                if (key_code !== 4'd3 || key_held !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL bounce_commit: got code=%0d held=%b expected 3/1", key_code, key_held);
                end
            end
        end
        pressedMask = 16'h0000;
        repeat (80) tick();
        testsRun++;
        if (key_held !== 1'b0 || key_code !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL bounce_release: got held=%b code=%0d expected 0/3", key_held, key_code);
        end
    endtask

    task automatic test_multi();
        waitSweepStart();
        pressedMask = 16'h0050;
        for (int k = 0; k < 128; k++) begin
            tick();
            testsRun++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL multi_same_row cycle %0d: got valid=%b held=%b expected 0/0", k, key_valid, key_held);
            end
        end
        pressedMask = 16'h8001;
        for (int k = 0; k < 64; k++) begin
            tick();
            testsRun++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL multi_corners cycle %0d: got valid=%b held=%b expected 0/0", k, key_valid, key_held);
            end
        end
        testsRun++;
        if (key_code !== 4'd3) begin testsFailed++; $display("[TB] FAIL multi_code: got %0d expected 3", key_code); end
        pressedMask = 16'h0000;
        repeat (32) tick();
    endtask

    task automatic test_reset_mid_debounce();
        waitSweepStart();
        pressedMask = 16'h0001;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        testsRun++;
        if (col_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_values: got col=%b code=%0d valid=%b held=%b expected 1110/0/0/0", col_out, key_code, key_valid, key_held);
        end
        tick();
        reset = 1'b0;
        testsRun++;
        if (key_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_release_valid: got %b expected 0", key_valid); end
        for (int k = 1; k <= 60; k++) begin
            tick();
            testsRun++;
            if (key_valid !== (k == 49)) begin testsFailed++; $display("[TB] FAIL midreset_valid cycle %0d: got %b expected %b", k, key_valid, (k == 49)); end
            testsRun++;
            if (key_held !== (k >= 49)) begin testsFailed++; $display("[TB] FAIL midreset_held cycle %0d: got %b expected %b", k, key_held, (k >= 49)); end
            testsRun++;
            if (key_code !== 4'd0) begin testsFailed++; $display("[TB] FAIL midreset_code cycle %0d: got %0d expected 0", k, key_code); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_rollover();
        test_release();
        test_bounce();
        test_multi();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Multiplexed 4x4 matrix-keypad scanner: the input-side counterpart of the team's multiplexed seven-segment driver. Drives one column low at a time, samples the four row lines, debounces the per-sweep result and emits a 4-bit key code with a one-cycle strobe. Sits between the board keypad pins and the PWM control logic, whose digit registers it feeds directly. Codes 0–9 are routed to the display digit inputs.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE`, default 4: consecutive identical sweeps required to commit a press or a release. Must be ≥ 1.
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high.
- `row_in`, in, 4: keypad rows, active-low (external pull-ups), asynchronous to `clock`.
- `col_out`, out, 4: column drive, active-low, exactly one bit low at all times.
- `key_code`, out, 4: last committed key, `row*4 + col`.
- `key_valid`, out, 1: one-cycle strobe when a new key is committed.
- `key_held`, out, 1: high while a committed key is pressed.

## Operation
- `row_in` passes through a 2-flop synchronizer before any use.
- **Column sequencer**
  - Dwell counter runs 0..SCAN_DIV-1.
  - On wrap, the column index advances 0→1→2→3→0.
  - `col_out` = ~(1 << col): col0 = 4'b1110, col3 = 4'b0111.
- **Sampling**
  - On dwell count SCAN_DIV-1, the synchronized rows for the current column are OR-accumulated into a sweep result.
  - Row r low while column c is driven means key (r,c) is down.
- **Sweep end** (the col3 sample): classify the sweep as one of:
  - NONE: no key seen.
  - KEY(code): exactly one key seen.
  - MULTI: two or more keys seen. Treated as NONE; ghosting is not resolved.
- **Stability tracking**
  - `stable_cnt` saturates at DEBOUNCE.
  - Reset to 1 when the sweep result differs from the previous sweep result; otherwise incremented.
- **FSM**, states RELEASED and PRESSED:
  - RELEASED, result KEY(k), `stable_cnt` reaches DEBOUNCE: go to PRESSED, `key_code`←k, pulse `key_valid`.
  - PRESSED, result KEY(k'), k'≠`key_code`, `stable_cnt` reaches DEBOUNCE: stay in PRESSED, `key_code`←k', pulse `key_valid` (roll-over without release).
  - PRESSED, result NONE, `stable_cnt` reaches DEBOUNCE: go to RELEASED. `key_code` holds its value. No strobe.
  - Same key held indefinitely: no further strobes.
- `key_held` = (state == PRESSED).
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, state RELEASED, dwell=0, `stable_cnt`=0, previous result=NONE.
- Reset asserted mid-sweep or mid-debounce discards all partial state. No strobe is emitted on the reset cycle or the cycle after it.

## Timing
- Sweep period: 4*SCAN_DIV cycles.
- Synchronizer latency: 2 cycles. SCAN_DIV ≥ 4 guarantees a row change made at column switch is settled by the sample point.
- The sweep result is registered on the cycle after the col3 sample.
- FSM update and `key_valid` occur on the following cycle, i.e. 2 cycles after the col3 sample.
- A key held stably from the start of sweep n commits after sweep n+DEBOUNCE-1.
- `key_code` and `key_held` change in the same cycle `key_valid` is high.
- A bounce shorter than one sample point never appears in a result.
- Any toggle between sweeps restarts the debounce count.

## Structure
- Shared package `keypad_pkg`: NUM_ROWS=4, NUM_COLS=4, result encoding (NONE, KEY, MULTI), FSM state encoding (RELEASED, PRESSED).
- Sub-module `keypad_row_sync`: 4-bit 2-flop synchronizer with reset to 4'b1111. Instantiated once.
- Scanner, classifier and debounce FSM live in the top module.
- Expected size: about 200 lines of RTL.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE=3, sweep = 16 cycles. The bench row model pulls row r low iff the pressed key's column is currently driven low.
- **Reset / idle:** hold reset 3 cycles, rows 4'b1111 for 200 cycles.
  - Required: `col_out` cycles 1110,1101,1011,0111 with 4 cycles each.
  - Required: `key_valid` never rises; `key_held`=0; `key_code`=0.
- **Single press:** press key (2,1) at a sweep boundary and hold.
  - Required: exactly one `key_valid` pulse, 2 cycles after the third sweep's col3 sample.
  - Required: `key_code`=9, `key_held`=1. No further pulse over 10 more sweeps.
- **Bounce:** toggle key (0,3) every 7 cycles for 64 cycles, then hold stable.
  - Required: no strobe during bouncing.
  - Required: one strobe with `key_code`=3 after 3 stable sweeps.
- **Release / roll-over:**
  - From PRESSED on code 9, switch to key (3,3). Required: strobe with `key_code`=15, `key_held` stays 1.
  - Then release all keys. Required: after 3 sweeps `key_held`=0, no strobe, `key_code` stays 15.
- **Multi-key / reset mid-debounce:**
  - Press (1,0) and (1,2) together. Required: no strobe.
  - Press (0,0) and assert reset during the second sweep, then release reset. Required: outputs return to reset values immediately; the first strobe (`key_code`=0) comes 3 full sweeps after reset release.
